note_sequencer: RTL

- Steps through the song ROM one note at a time and holds each note for its programmed number of beats.
- Inserts a one-beat rest between notes.
- Drives the current note code to the tone generator.
- Drives the current 6-bit duration and an address carry-out to the song-completion judge, which returns song_done.
- Sits directly upstream of the judge stage, between the song ROM and the judge/tone-generator pair.

---
 rtl/note_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/note_sequencer.sv
// Song sequencer: walks the song ROM, holds each note for its beat count,
// inserts a one-beat rest between notes and flags completion to the judge.
module note_sequencer #(
   parameter int ADDR_W   = 7,
   parameter int NOTE_W   = 6,
   parameter int BEAT_DIV = 48
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play,
   input  logic              song_done,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [NOTE_W-1:0] rom_note,
   input  logic [5:0]        rom_duration,
   output logic [NOTE_W-1:0] note,
   output logic [5:0]        duration,
   output logic              co
);

   localparam int PW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(BEAT_DIV - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      PLAY,
      GAP,
      DONE
   } state_t;

   state_t         state;
   logic [PW-1:0]  prescaler;
   logic [5:0]     beat_cnt;
   logic           tick;

   assign tick = (prescaler == PS_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rom_addr  <= '0;
         note      <= '0;
         duration  <= '0;
         co        <= 1'b0;
         prescaler <= '0;
         beat_cnt  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (play)
                  state <= FETCH;
            end
            FETCH: begin
               state <= LOAD;
            end
            LOAD: begin
               duration <= rom_duration;
               if (rom_duration == 6'd0) begin
                  note  <= '0;
                  state <= DONE;
               end else begin
                  note      <= rom_note;
                  beat_cnt  <= rom_duration;
                  prescaler <= '0;
                  state     <= PLAY;
               end
            end
            PLAY: begin
               // pause freezes the beat clock, so a deferred tick is never lost
               if (play) begin
                  if (tick) begin
                     prescaler <= '0;
                     beat_cnt  <= beat_cnt - 6'd1;
                     if (beat_cnt == 6'd1) begin
                        note  <= '0;
                        state <= GAP;
                     end
                  end else begin
                     prescaler <= prescaler + 1'b1;
                  end
               end
            end
            GAP: begin
               if (play) begin
                  if (tick) begin
                     prescaler <= '0;
                     if (rom_addr == ADDR_LAST) begin
                        co    <= 1'b1;
                        state <= DONE;
                     end else begin
                        rom_addr <= rom_addr + 1'b1;
                        state    <= FETCH;
                     end
                  end else begin
                     prescaler <= prescaler + 1'b1;
                  end
               end
            end
            DONE: begin
               note <= '0;
               if (song_done && !play) begin
                  state    <= IDLE;
                  rom_addr <= '0;
                  co       <= 1'b0;
                  duration <= '0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
